mips_cpu_mem_unit: RTL and testbench

Load/store unit between the CPU control FSM and the Avalon memory-mapped master port. It accepts one memory request per handshake (fetch or data) and forms a word-aligned address and byteenable. It holds read/write stable across waitrequest stalls and captures readdata the cycle after acceptance. It returns extended or merged load results, or flags errors, to the core.

---
 rtl/mips_cpu_pkg.sv | 63 ++++++
 rtl/mips_cpu_load_format.sv | 36 +++
 rtl/mips_cpu_mem_unit.sv | 165 ++++++++++++++++
 tb/tb_mips_cpu_mem_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types and helpers for the MIPS CPU memory path.
// MEM_UNIT_UNALIGNED_EN enables the LWL/LWR unaligned loads.
package mips_cpu_pkg;

   typedef enum logic [3:0] {
      OpFetch = 4'd0,
      OpLb    = 4'd1,
      OpLbu   = 4'd2,
      OpLh    = 4'd3,
      OpLhu   = 4'd4,
      OpLw    = 4'd5,
      OpLwl   = 4'd6,
      OpLwr   = 4'd7,
      OpSb    = 4'd8,
      OpSh    = 4'd9,
      OpSw    = 4'd10
   } mem_op_t;

   typedef enum logic [1:0] {
      StIdle,
      StBus,
      StRdata,
      StResp
   } mem_state_t;

   localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

   function automatic logic mem_op_is_store(input mem_op_t op);
      return op inside {OpSb, OpSh, OpSw};
   endfunction

   // True when the request must be refused without touching the bus.
   function automatic logic mem_op_reject(input mem_op_t op, input logic [1:0] a);
      case (op)
         OpLb, OpLbu, OpSb:    return 1'b0;
         OpLh, OpLhu, OpSh:    return a[0];
         OpLw, OpSw, OpFetch:  return a != 2'b00;
`ifdef MEM_UNIT_UNALIGNED_EN
         OpLwl, OpLwr:         return 1'b0;
`else
         OpLwl, OpLwr:         return 1'b1;
`endif
         default:              return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] mem_op_byteenable(input mem_op_t op, input logic [1:0] a);
      case (op)
         OpLb, OpLbu, OpSb: return 4'b0001 << a;
         OpLh, OpLhu, OpSh: return a[1] ? 4'b1100 : 4'b0011;
         default:           return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] mem_op_wdata(input mem_op_t op, input logic [31:0] w);
      case (op)
         OpSb:    return {4{w[7:0]}};
         OpSh:    return {2{w[15:0]}};
         default: return w;
      endcase
   endfunction

endpackage

// File: rtl/mips_cpu_load_format.sv
// Load result formatting: lane select, sign/zero extension and LWL/LWR merge.
// The merge is only reachable when MEM_UNIT_UNALIGNED_EN admits LWL/LWR upstream.
module mips_cpu_load_format
   import mips_cpu_pkg::*;
(
   input  mem_op_t     op,
   input  logic [1:0]  addr,
   input  logic [31:0] word,
   input  logic [31:0] rt_old,
   output logic [31:0] result
);

   logic [7:0]  byte_w;
   logic [15:0] half_w;
   logic [4:0]  lwl_sh;
   logic [4:0]  lwr_sh;

   always_comb begin
      byte_w = word[{addr, 3'b000} +: 8];
      half_w = addr[1] ? word[31:16] : word[15:0];
      // 8*(3-k) == {~k,3'b000} for a 2-bit k
      lwl_sh = {~addr, 3'b000};
      lwr_sh = {addr, 3'b000};
      result = word;
      case (op)
         OpLb:    result = {{24{byte_w[7]}}, byte_w};
         OpLbu:   result = {24'h0, byte_w};
         OpLh:    result = {{16{half_w[15]}}, half_w};
         OpLhu:   result = {16'h0, half_w};
         OpLwl:   result = (word << lwl_sh) | (rt_old & ~(32'hFFFFFFFF << lwl_sh));
         OpLwr:   result = (word >> lwr_sh) | (rt_old & ~(32'hFFFFFFFF >> lwr_sh));
         default: result = word;
      endcase
   end

endmodule

// File: rtl/mips_cpu_mem_unit.sv
// Load/store unit bridging the core's request port to an Avalon-MM master.
// LWL/LWR are accepted only when MEM_UNIT_UNALIGNED_EN is defined.
module mips_cpu_mem_unit
   import mips_cpu_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_rt_old,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   input  logic        waitrequest,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata
);

   mem_state_t  state_q, state_d;
   mem_op_t     op_q, op_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic [31:0] rt_old_q, rt_old_d;
   logic [31:0] address_q, address_d;
   logic [3:0]  byteenable_q, byteenable_d;
   logic [31:0] writedata_q, writedata_d;
   logic        read_q, read_d;
   logic        write_q, write_d;
   logic [31:0] cnt_q, cnt_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;

   mem_op_t     req_op_e;
   logic [31:0] load_result;

   assign req_op_e = mem_op_t'(req_op);

   mips_cpu_load_format u_load_format (
      .op     (op_q),
      .addr   (addr_lo_q),
      .word   (readdata),
      .rt_old (rt_old_q),
      .result (load_result)
   );

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_lo_d    = addr_lo_q;
      rt_old_d     = rt_old_q;
      address_d    = address_q;
      byteenable_d = byteenable_q;
      writedata_d  = writedata_q;
      read_d       = read_q;
      write_d      = write_q;
      cnt_d        = cnt_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = resp_rdata_q;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               op_d      = req_op_e;
               addr_lo_d = req_addr[1:0];
               rt_old_d  = req_rt_old;
               if (mem_op_reject(req_op_e, req_addr[1:0])) begin
                  state_d      = StResp;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  state_d      = StBus;
                  address_d    = {req_addr[31:2], 2'b00};
                  byteenable_d = mem_op_byteenable(req_op_e, req_addr[1:0]);
                  writedata_d  = mem_op_wdata(req_op_e, req_wdata);
                  read_d       = !mem_op_is_store(req_op_e);
                  write_d      = mem_op_is_store(req_op_e);
                  cnt_d        = '0;
               end
            end
         end
         StBus: begin
            if (waitrequest) begin
               cnt_d = cnt_q + 32'd1;
               if (MAX_WAIT != 0 && cnt_q == 32'(MAX_WAIT - 1)) begin
                  read_d       = 1'b0;
                  write_d      = 1'b0;
                  state_d      = StResp;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end
            end else begin
               read_d  = 1'b0;
               write_d = 1'b0;
               if (read_q) begin
                  state_d = StRdata;
               end else begin
                  state_d      = StResp;
                  resp_valid_d = 1'b1;
                  resp_rdata_d = '0;
               end
            end
         end
         StRdata: begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_result;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         op_q         <= OpFetch;
         addr_lo_q    <= '0;
         rt_old_q     <= '0;
         address_q    <= '0;
         byteenable_q <= '0;
         writedata_q  <= '0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_lo_q    <= addr_lo_d;
         rt_old_q     <= rt_old_d;
         address_q    <= address_d;
         byteenable_q <= byteenable_d;
         writedata_q  <= writedata_d;
         read_q       <= read_d;
         write_q      <= write_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign address    = address_q;
   assign byteenable = byteenable_q;
   assign writedata  = writedata_q;
   assign read       = read_q;
   assign write      = write_q;

endmodule

// File: tb/tb_mips_cpu_mem_unit.sv
// Scoreboard bench for mips_cpu_mem_unit with a small stalling Avalon slave.
module tb_mips_cpu_mem_unit;
   import mips_cpu_pkg::*;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_rt_old;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic        waitrequest;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;

   exp_t        sb_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          n_resp = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          resp_cyc = 0;
   int          stall_left = 0;
   logic        rd_pend = 1'b0;
   logic [31:0] mem_word = '0;

   mips_cpu_mem_unit #(.MAX_WAIT(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_rt_old  (req_rt_old),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .address     (address),
      .read        (read),
      .write       (write),
      .waitrequest (waitrequest),
      .writedata   (writedata),
      .byteenable  (byteenable),
      .readdata    (readdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Avalon slave: stalls for stall_left cycles, readdata valid only the cycle after acceptance.
   initial begin
      waitrequest = 1'b0;
      readdata    = 32'hDEADBEEF;
      forever begin
         @(negedge clk);
         readdata = rd_pend ? mem_word : 32'hDEADBEEF;
         rd_pend  = 1'b0;
         if (reset && (read || write)) begin
            if (stall_left != 0) begin
               waitrequest = 1'b1;
               stall_left--;
            end else begin
               waitrequest = 1'b0;
               rd_pend     = read;
            end
         end else begin
            waitrequest = 1'b0;
         end
      end
   end

   // Response monitor
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (reset && resp_valid) begin
         n_resp++;
         resp_cyc = cyc;
         chk("ready_low_during_resp", {31'b0, req_ready}, 32'd0);
         if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_resp: got resp_valid=1 rdata=%h expected no response",
                     resp_rdata);
         end else begin
            e = sb_q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rt, input logic push, input logic [31:0] exp_rd,
                        input logic exp_err);
      int g;
      g = 0;
      @(negedge clk);
      while (!req_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      chk("req_ready_before_issue", {31'b0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_op     = op;
      req_addr   = addr;
      req_wdata  = wd;
      req_rt_old = rt;
      acc_cyc    = cyc;
      if (push) sb_q.push_back('{rdata: exp_rd, err: exp_err});
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'h5555_5555;
   endtask

   task automatic txn(input string name, input logic [3:0] op, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rt, input logic [31:0] word,
                      input int stalls, input int bus_cyc, input logic [3:0] be,
                      input logic [31:0] wdx, input logic [31:0] exp_rd, input logic exp_err,
                      input int lat);
      int snap, cnt, g;
      logic st;
      st         = op inside {OpSb, OpSh, OpSw};
      mem_word   = word;
      stall_left = stalls;
      snap       = n_resp;
      issue(op, addr, wd, rt, 1'b1, exp_rd, exp_err);
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!(read || write)) break;
         cnt++;
         chk({name, "_address"}, address, {addr[31:2], 2'b00});
         chk({name, "_byteenable"}, {28'b0, byteenable}, {28'b0, be});
         chk({name, "_rw"}, {30'b0, read, write}, st ? 32'd1 : 32'd2);
         if (st) chk({name, "_writedata"}, writedata, wdx);
      end
      chk({name, "_bus_cycles"}, cnt, bus_cyc);
      g = 0;
      while (n_resp == snap && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (n_resp == snap) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s_resp_timeout: got no resp_valid expected one", name);
      end else begin
         chk({name, "_latency"}, resp_cyc - acc_cyc, lat);
      end
   endtask

   initial begin
      int snap;
      reset      = 1'b0;
      req_valid  = 1'b0;
      req_op     = '0;
      req_addr   = '0;
      req_wdata  = '0;
      req_rt_old = '0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
      chk("rst_rw", {30'b0, read, write}, 32'd0);
      chk("rst_address", address, 32'd0);
      chk("rst_writedata", writedata, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_byteenable", {28'b0, byteenable}, 32'd0);
      reset = 1'b1;

      txn("lw", OpLw, 32'h1000_0004, 0, 0, 32'h8899AABB, 0, 1, 4'b1111, 0,
          32'h8899AABB, 1'b0, 3);
      repeat (2) @(negedge clk);
      chk("rdata_held", resp_rdata, 32'h8899AABB);
      txn("lb", OpLb, 32'h1000_0003, 0, 0, 32'h80123456, 0, 1, 4'b1000, 0,
          32'hFFFFFF80, 1'b0, 3);
      txn("lbu", OpLbu, 32'h1000_0003, 0, 0, 32'h80123456, 0, 1, 4'b1000, 0,
          32'h00000080, 1'b0, 3);
      txn("lh", OpLh, 32'h1000_0002, 0, 0, 32'h80123456, 0, 1, 4'b1100, 0,
          32'hFFFF8012, 1'b0, 3);
      txn("lhu", OpLhu, 32'h1000_0000, 0, 0, 32'h80123456, 0, 1, 4'b0011, 0,
          32'h00003456, 1'b0, 3);
      txn("fetch", OpFetch, RESET_VECTOR, 0, 0, 32'h27BDFFF0, 0, 1, 4'b1111, 0,
          32'h27BDFFF0, 1'b0, 3);
      txn("sb", OpSb, 32'h3001, 32'h0000_00A5, 0, 0, 0, 1, 4'b0010, 32'hA5A5A5A5,
          32'h0, 1'b0, 2);
      txn("sh_stall", OpSh, 32'h2002, 32'h0000_BEEF, 0, 0, 3, 4, 4'b1100, 32'hBEEFBEEF,
          32'h0, 1'b0, 5);
      txn("sw", OpSw, 32'h4000, 32'h1234_5678, 0, 0, 1, 2, 4'b1111, 32'h12345678,
          32'h0, 1'b0, 3);
      txn("lw_misaligned", OpLw, 32'h1001, 0, 0, 0, 0, 0, 4'b0000, 0, 32'h0, 1'b1, 1);
      txn("sh_misaligned", OpSh, 32'h2001, 32'hBEEF, 0, 0, 0, 0, 4'b0000, 0, 32'h0, 1'b1, 1);
      txn("bad_op", 4'hB, 32'h2000, 0, 0, 0, 0, 0, 4'b0000, 0, 32'h0, 1'b1, 1);
`ifdef MEM_UNIT_UNALIGNED_EN
      txn("lwl", OpLwl, 32'h1001, 0, 32'hAABBCCDD, 32'h44332211, 0, 1, 4'b1111, 0,
          32'h2211CCDD, 1'b0, 3);
      txn("lwr", OpLwr, 32'h1002, 0, 32'hAABBCCDD, 32'h44332211, 0, 1, 4'b1111, 0,
          32'hAABB4433, 1'b0, 3);
`else
      txn("lwl", OpLwl, 32'h1001, 0, 32'hAABBCCDD, 32'h44332211, 0, 0, 4'b0000, 0,
          32'h0, 1'b1, 1);
      txn("lwr", OpLwr, 32'h1002, 0, 32'hAABBCCDD, 32'h44332211, 0, 0, 4'b0000, 0,
          32'h0, 1'b1, 1);
`endif
      txn("timeout", OpLw, 32'h5000, 0, 0, 32'h11111111, 1000, 4, 4'b1111, 0,
          32'h0, 1'b1, 5);
      stall_left = 0;

      // Reset in the middle of a stalled read must drop read at once and yield no response.
      stall_left = 1000;
      snap = n_resp;
      issue(OpLw, 32'h6000, 0, 0, 1'b0, 0, 1'b0);
      @(negedge clk);
      chk("midrst_read_before", {31'b0, read}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_read_async", {31'b0, read}, 32'd0);
      chk("midrst_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      reset      = 1'b1;
      stall_left = 0;
      repeat (6) @(negedge clk);
      chk("midrst_no_resp", n_resp - snap, 32'd0);
      chk("midrst_idle_rw", {30'b0, read, write}, 32'd0);

      txn("lw_after_rst", OpLw, 32'h7008, 0, 0, 32'hCAFEF00D, 0, 1, 4'b1111, 0,
          32'hCAFEF00D, 1'b0, 3);
      chk("scoreboard_empty", sb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
